// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between instruction fetch and data access.
// Fetched words live in a one-entry buffer; load results live in a data buffer.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_instr,
    output logic              if_stall,
    input  logic              dm_en,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wd,
    output logic [DATA_W-1:0] dm_rd,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_D_RESP} state_t;

    state_t            r_state,      w_state_nx;
    logic              r_mem_req,    w_mem_req_nx;
    logic              r_mem_we,     w_mem_we_nx;
    logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nx;
    logic [DATA_W-1:0] r_mem_wd,     w_mem_wd_nx;
    logic              r_tgt_d,      w_tgt_d_nx;
    logic [ADDR_W-1:0] r_ireq_addr,  w_ireq_addr_nx;
    logic              r_ibuf_valid, w_ibuf_valid_nx;
    logic [ADDR_W-1:0] r_ibuf_addr,  w_ibuf_addr_nx;
    logic [DATA_W-1:0] r_ibuf_data,  w_ibuf_data_nx;
    logic [DATA_W-1:0] r_dbuf,       w_dbuf_nx;
    logic              r_last_d,     w_last_d_nx;

    logic w_if_stall;
    logic w_d_pend;
    logic w_i_pend;

    assign w_if_stall = ~(r_ibuf_valid && (r_ibuf_addr == if_addr));
    assign w_d_pend   = dm_en && (r_state == S_IDLE);
    assign w_i_pend   = w_if_stall && (r_state == S_IDLE);

    assign if_stall = w_if_stall;
    assign if_instr = r_ibuf_data;
    assign dm_stall = dm_en && (r_state != S_D_RESP);
    assign dm_rd    = r_dbuf;
    assign mem_req  = r_mem_req;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_wd   = r_mem_wd;

    // State and buffer registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wd     <= '0;
            r_tgt_d      <= 1'b0;
            r_ireq_addr  <= '0;
            r_ibuf_valid <= 1'b0;
            r_ibuf_addr  <= '0;
            r_ibuf_data  <= '0;
            r_dbuf       <= '0;
            r_last_d     <= 1'b1;
        end else begin
            r_state      <= w_state_nx;
            r_mem_req    <= w_mem_req_nx;
            r_mem_we     <= w_mem_we_nx;
            r_mem_addr   <= w_mem_addr_nx;
            r_mem_wd     <= w_mem_wd_nx;
            r_tgt_d      <= w_tgt_d_nx;
            r_ireq_addr  <= w_ireq_addr_nx;
            r_ibuf_valid <= w_ibuf_valid_nx;
            r_ibuf_addr  <= w_ibuf_addr_nx;
            r_ibuf_data  <= w_ibuf_data_nx;
            r_dbuf       <= w_dbuf_nx;
            r_last_d     <= w_last_d_nx;
        end
    end

    // Next-state: arbitrate in IDLE, handshake in REQ, collect response in WAIT
    always_comb begin
        w_state_nx      = r_state;
        w_mem_req_nx    = r_mem_req;
        w_mem_we_nx     = r_mem_we;
        w_mem_addr_nx   = r_mem_addr;
        w_mem_wd_nx     = r_mem_wd;
        w_tgt_d_nx      = r_tgt_d;
        w_ireq_addr_nx  = r_ireq_addr;
        w_ibuf_valid_nx = r_ibuf_valid;
        w_ibuf_addr_nx  = r_ibuf_addr;
        w_ibuf_data_nx  = r_ibuf_data;
        w_dbuf_nx       = r_dbuf;
        w_last_d_nx     = r_last_d;

        case (r_state)
            S_IDLE: begin
                // On a conflict, data goes first unless it was served last
                if (w_d_pend && !(w_i_pend && r_last_d)) begin
                    w_mem_req_nx  = 1'b1;
                    w_mem_we_nx   = dm_we;
                    w_mem_addr_nx = dm_addr;
                    w_mem_wd_nx   = dm_wd;
                    w_tgt_d_nx    = 1'b1;
                    w_state_nx    = S_REQ;
                end else if (w_i_pend) begin
                    w_mem_req_nx   = 1'b1;
                    w_mem_we_nx    = 1'b0;
                    w_mem_addr_nx  = if_addr;
                    w_mem_wd_nx    = '0;
                    w_tgt_d_nx     = 1'b0;
                    w_ireq_addr_nx = if_addr;
                    w_state_nx     = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    w_mem_req_nx = 1'b0;
                    w_state_nx   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    if (r_tgt_d) begin
                        if (!r_mem_we) begin
                            w_dbuf_nx = mem_rdata;
                        end else if (r_mem_addr == r_ibuf_addr) begin
                            w_ibuf_valid_nx = 1'b0;
                        end
                        w_last_d_nx = 1'b1;
                        w_state_nx  = S_D_RESP;
                    end else begin
                        // Fill with the address actually fetched, not the current PC
                        w_ibuf_data_nx  = mem_rdata;
                        w_ibuf_addr_nx  = r_ireq_addr;
                        w_ibuf_valid_nx = 1'b1;
                        w_last_d_nx     = 1'b0;
                        w_state_nx      = S_IDLE;
                    end
                end
            end
            S_D_RESP: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory slave model, transaction-level reference
// memory, directed vectors and corner sequences, then randomized traffic.
module tb_mem_port_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int LIMIT = 200;

    logic          clock;
    logic          reset;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_instr;
    logic          if_stall;
    logic          dm_en;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wd;
    logic [DW-1:0] dm_rd;
    logic          dm_stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .if_addr(if_addr), .if_instr(if_instr), .if_stall(if_stall),
        .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
        .dm_rd(dm_rd), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Slave configuration and state
    int gnt_mode = 1;      // 0 never, 1 always, 2 random
    int rv_min   = 1;
    int rv_max   = 1;
    int rv_cnt   = 0;
    logic [DW-1:0] rv_data = '0;
    logic [AW-1:0] hs_q[$];

    logic [DW-1:0] smem    [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 32'h0)   return 32'h2100_0000;
        if (a == 32'h100) return 32'h1111_0100;
        return 32'h5EED_0000 ^ (a * 32'd2654435761);
    endfunction

    function automatic logic [DW-1:0] slave_rd(input logic [AW-1:0] a);
        if (smem.exists(a)) return smem[a];
        return init_val(a);
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_dm(output int lat);
        lat = 0;
        do begin tick(); lat++; end while (dm_stall && lat < 60);
        if (dm_stall) begin
            n_chk++; n_fail++;
            $display("FAIL dm_timeout: dm_stall still %b after %0d cycles", dm_stall, lat);
        end
    endtask

    task automatic wait_if();
        int lat;
        lat = 0;
        do begin tick(); lat++; end while (if_stall && lat < 60);
        if (if_stall) begin
            n_chk++; n_fail++;
            $display("FAIL if_timeout: if_stall still %b after %0d cycles", if_stall, lat);
        end
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory slave: grants, stores on handshake, responds rv_cnt cycles later
    initial begin
        logic g;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clock);
            mem_rvalid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rv_data;
                end
            end
            case (gnt_mode)
                0:       g = 1'b0;
                1:       g = 1'b1;
                default: g = 1'($urandom_range(1, 0));
            endcase
            mem_gnt = g && (rv_cnt == 0);
            if (mem_req && mem_gnt && reset) begin
                hs_q.push_back(mem_addr);
                if (mem_we) begin
                    smem[mem_addr] = mem_wd;
                    rv_data = $urandom;
                end else begin
                    rv_data = slave_rd(mem_addr);
                end
                rv_cnt = $urandom_range(rv_max, rv_min);
            end
        end
    end

    // Reference checker: presented words must match memory as of completed stores
    initial begin
        int if_cnt;
        int dm_cnt;
        if_cnt = 0; dm_cnt = 0;
        forever begin
            @(posedge clock); #1;
            if (!reset) begin
                if_cnt = 0; dm_cnt = 0;
            end else begin
                if (!if_stall) chk("if_instr_ref", if_instr, ref_rd(if_addr));
                if (dm_en && !dm_stall) begin
                    if (dm_we) ref_mem[dm_addr] = dm_wd;
                    else       chk("dm_rd_ref", dm_rd, ref_rd(dm_addr));
                end
                if (if_stall) begin
                    if_cnt++;
                    if (if_cnt == LIMIT) begin
                        n_chk++; n_fail++;
                        $display("FAIL if_starved: if_stall held %0d cycles", if_cnt);
                    end
                end else begin
                    if (if_cnt > 0) chk("if_latency", 32'(if_cnt < LIMIT), 32'h1);
                    if_cnt = 0;
                end
                if (dm_en && dm_stall) begin
                    dm_cnt++;
                    if (dm_cnt == LIMIT) begin
                        n_chk++; n_fail++;
                        $display("FAIL dm_starved: dm_stall held %0d cycles", dm_cnt);
                    end
                end else begin
                    if (dm_cnt > 0) chk("dm_latency", 32'(dm_cnt < LIMIT), 32'h1);
                    dm_cnt = 0;
                end
            end
        end
    end

    initial begin
        int lat;
        vecs[0] = '{we: 1'b0, addr: 32'h100, wd: 32'h0,         exp_rd: 32'h1111_0100};
        vecs[1] = '{we: 1'b1, addr: 32'h104, wd: 32'hCAFE_0001, exp_rd: 32'h0};
        vecs[2] = '{we: 1'b0, addr: 32'h104, wd: 32'h0,         exp_rd: 32'hCAFE_0001};
        vecs[3] = '{we: 1'b0, addr: 32'h104, wd: 32'h0,         exp_rd: 32'hCAFE_0001};
        vecs[4] = '{we: 1'b1, addr: 32'h100, wd: 32'h0BAD_F00D, exp_rd: 32'h0};
        vecs[5] = '{we: 1'b0, addr: 32'h100, wd: 32'h0,         exp_rd: 32'h0BAD_F00D};

        reset = 1'b0; if_addr = '0;
        dm_en = 1'b1; dm_we = 1'b0; dm_addr = '0; dm_wd = '0;

        // Reset values
        repeat (2) tick();
        chk("rst_mem_req",  32'(mem_req),  32'h0);
        chk("rst_if_stall", 32'(if_stall), 32'h1);
        chk("rst_if_instr", if_instr,      32'h0);
        chk("rst_dm_stall", 32'(dm_stall), 32'h1);
        chk("rst_dm_rd",    dm_rd,         32'h0);
        dm_en = 1'b0;
        #1 chk("rst_dm_stall_low", 32'(dm_stall), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        chk("boot_req",      32'(mem_req),  32'h1);
        chk("boot_addr",     mem_addr,      32'h0);
        chk("boot_we",       32'(mem_we),   32'h0);
        tick();
        chk("boot_req_drop", 32'(mem_req),  32'h0);
        chk("boot_stall2",   32'(if_stall), 32'h1);
        tick();
        chk("boot_stall3",   32'(if_stall), 32'h0);
        chk("boot_instr",    if_instr,      32'h2100_0000);

        // Conflict with last served = fetch: data first, then the fetch
        if_addr = 32'h4; dm_en = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        tick();
        chk("cf_req_addr",  mem_addr,       32'h100);
        chk("cf_if_stall",  32'(if_stall),  32'h1);
        tick();
        chk("cf_dm_stall2", 32'(dm_stall),  32'h1);
        tick();
        chk("cf_dm_stall3", 32'(dm_stall),  32'h0);
        chk("cf_dm_rd",     dm_rd,          32'h1111_0100);
        dm_en = 1'b0;
        tick();
        chk("cf_gap_req",   32'(mem_req),   32'h0);
        tick();
        chk("cf_i_req",     32'(mem_req),   32'h1);
        chk("cf_i_addr",    mem_addr,       32'h4);
        wait_if();
        chk("cf_instr",     if_instr,       ref_rd(32'h4));

        // Fairness: D, I, D with data continuously requesting
        hs_q.delete();
        if_addr = 32'h40; dm_en = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        wait_dm(lat);
        chk("rr_rd0", dm_rd, ref_rd(32'h200));
        dm_addr = 32'h204;
        wait_dm(lat);
        chk("rr_rd1", dm_rd, ref_rd(32'h204));
        dm_en = 1'b0;
        wait_if();
        chk("rr_count", 32'(hs_q.size()), 32'd3);
        if (hs_q.size() >= 3) begin
            chk("rr_order0", hs_q[0], 32'h200);
            chk("rr_order1", hs_q[1], 32'h40);
            chk("rr_order2", hs_q[2], 32'h204);
        end

        // Table of data accesses at minimum latency, fetch buffer hitting
        for (int i = 0; i < 6; i++) begin
            dm_en = 1'b1; dm_we = vecs[i].we; dm_addr = vecs[i].addr; dm_wd = vecs[i].wd;
            tick();
            chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
            chk($sformatf("vec%0d_we", i), 32'(mem_we), 32'(vecs[i].we));
            if (vecs[i].we) chk($sformatf("vec%0d_wd", i), mem_wd, vecs[i].wd);
            wait_dm(lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat + 1), 32'd3);
            if (!vecs[i].we) chk($sformatf("vec%0d_rd", i), dm_rd, vecs[i].exp_rd);
            dm_en = 1'b0;
            tick();
        end

        // Grant withheld: everything holds
        gnt_mode = 0;
        if_addr = 32'h80; dm_en = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        tick();
        chk("gh_req0",  32'(mem_req), 32'h1);
        chk("gh_addr0", mem_addr,     32'h80);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("gh_req%0d", k + 1),  32'(mem_req),  32'h1);
            chk($sformatf("gh_addr%0d", k + 1), mem_addr,      32'h80);
            chk($sformatf("gh_ifs%0d", k + 1),  32'(if_stall), 32'h1);
            chk($sformatf("gh_dms%0d", k + 1),  32'(dm_stall), 32'h1);
        end
        gnt_mode = 1;
        wait_dm(lat);
        chk("gh_dm_rd", dm_rd, ref_rd(32'h300));
        dm_en = 1'b0;
        wait_if();
        chk("gh_instr", if_instr, ref_rd(32'h80));

        // Redirect while a fetch is in WAIT
        rv_min = 3; rv_max = 3;
        hs_q.delete();
        if_addr = 32'h8;
        tick();
        chk("rd_addr8", mem_addr, 32'h8);
        tick();
        if_addr = 32'h14;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rd_stall%0d", k), 32'(if_stall), 32'h1);
        end
        wait_if();
        chk("rd_instr", if_instr, ref_rd(32'h14));
        chk("rd_count", 32'(hs_q.size()), 32'd2);
        if (hs_q.size() >= 2) begin
            chk("rd_first",  hs_q[0], 32'h8);
            chk("rd_second", hs_q[1], 32'h14);
        end
        rv_min = 1; rv_max = 1;

        // Coherency: store to the buffered address
        if_addr = 32'h4;
        wait_if();
        dm_en = 1'b1; dm_we = 1'b1; dm_addr = 32'h4; dm_wd = 32'h0000_DEAD;
        wait_dm(lat);
        chk("coh_invalidate", 32'(if_stall), 32'h1);
        dm_en = 1'b0; dm_we = 1'b0;
        wait_if();
        chk("coh_refetch", if_instr, 32'h0000_DEAD);

        // Async reset in WAIT; the late response must be dropped
        rv_min = 3; rv_max = 3;
        if_addr = 32'h30;
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        chk("ar_wait_req",   32'(mem_req),  32'h0);
        chk("ar_wait_instr", if_instr,      32'h0);
        chk("ar_wait_dm_rd", dm_rd,         32'h0);
        chk("ar_wait_stall", 32'(if_stall), 32'h1);
        if_addr = 32'h34;
        tick();
        reset = 1'b1;
        tick();
        chk("ar_post_stall", 32'(if_stall), 32'h1);
        wait_if();
        chk("ar_post_instr", if_instr, ref_rd(32'h34));
        rv_min = 1; rv_max = 1;

        // Async reset in REQ drops mem_req without a clock edge
        gnt_mode = 0;
        if_addr = 32'h38;
        tick();
        chk("ar_req_up", 32'(mem_req), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("ar_req_down", 32'(mem_req), 32'h0);
        chk("ar_req_addr", mem_addr,     32'h0);
        tick();
        reset = 1'b1;
        gnt_mode = 1;
        wait_if();
        chk("ar_req_instr", if_instr, ref_rd(32'h38));

        // Randomized traffic against the reference checker
        gnt_mode = 2; rv_min = 1; rv_max = 4;
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (dm_en && !dm_stall) begin
                if ($urandom_range(1, 0) == 0) begin
                    dm_en = 1'b0;
                end else begin
                    dm_we   = 1'($urandom_range(1, 0));
                    dm_addr = 32'($urandom_range(15, 0)) << 2;
                    dm_wd   = $urandom;
                end
            end else if (!dm_en && $urandom_range(2, 0) == 0) begin
                dm_en   = 1'b1;
                dm_we   = 1'($urandom_range(1, 0));
                dm_addr = 32'($urandom_range(15, 0)) << 2;
                dm_wd   = $urandom;
            end
            if ((!if_stall || $urandom_range(15, 0) == 0) && $urandom_range(3, 0) == 0)
                if_addr = 32'($urandom_range(15, 0)) << 2;
        end
        if (dm_en) begin
            wait_dm(lat);
            dm_en = 1'b0;
        end
        wait_if();
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
